weight_fetch_seq: RTL
=====================

Name: weight_fetch_seq

Overview:
Sequences one neuron's dot-product pass. It walks the weight ROM address space 0..NUM_INPUTS-1 and accounts for the ROM's one-cycle registered read latency. Each weight is paired with the matching activation from an input stream. The resulting {x, w} pairs go to the downstream MAC over a valid/ready handshake with full backpressure. It sits between the layer controller (start/done), the activation source, the weight ROM and the neuron MAC.

Parameters:
DATA_SIZE, 32, width of activations and weights
ADDR_SIZE, 10, weight ROM address width
NUM_INPUTS, 784, weights per neuron pass (1..2**ADDR_SIZE)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a pass; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final pair is accepted by the MAC
in_valid  input  1  activation available
in_data  input  DATA_SIZE  activation value
in_ready  output  1  activation consumed this cycle
rom_r_addr  output  ADDR_SIZE  ROM read address
rom_r_en  output  1  ROM read enable
rom_weight  input  DATA_SIZE  ROM registered data, valid the cycle after rom_r_en
mac_clear  output  1  one-cycle pulse: clear MAC accumulator at pass start
mac_valid  output  1  pair valid
mac_x  output  DATA_SIZE  activation of the pair
mac_w  output  DATA_SIZE  weight of the pair (driven combinationally from rom_weight)
mac_last  output  1  marks pair NUM_INPUTS-1
mac_ready  input  1  MAC accepts pair

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; issue count=0; busy, done, mac_clear, mac_valid, mac_last, rom_r_en and in_ready are all 0; mac_x=0; rom_r_addr=0. Reset mid-pass aborts the pass, and no done is generated.
- States:
  - IDLE -> RUN on start. In that same edge, pulse mac_clear (high the next cycle) and set busy=1.
  - RUN -> DRAIN when the last address is issued.
  - DRAIN -> DONE when the final pair handshakes (mac_valid & mac_ready & mac_last).
  - DONE -> IDLE after one cycle, with done=1 during DONE.
  - start is ignored outside IDLE.
- Pipeline: stage-1 issues the read, stage-2 holds the output pair.
  - advance = !mac_valid | mac_ready.
- Issue in RUN: when in_valid & advance, then in_ready=1, rom_r_en=1 and rom_r_addr=count (combinational).
  - Register mac_x<=in_data, mac_valid<=1 and mac_last<=(count==NUM_INPUTS-1).
  - Increment count.
  - rom_weight presents w[count] on the next cycle, aligned with mac_x.
- If advance & !issue, then mac_valid<=0.
- If !advance (stall), then in_ready=0, rom_r_en=0, and mac_x/mac_valid/mac_last hold. The ROM holds its output while r_en=0, so mac_w stays stable with no skid buffer.
- in_ready and rom_r_en are always identical. Both are 0 outside RUN.
- Throughput: one pair per cycle with in_valid and mac_ready held high.
- Latency: start edge -> first mac_valid at least 2 cycles later (RUN entry, then issue). The last handshake is followed by done the next cycle.
- count is ADDR_SIZE+1 bits wide. It resets to 0 on entering RUN, and never wraps.
- NUM_INPUTS=1: the first pair carries mac_last=1, and RUN goes to DRAIN immediately.
- A start arriving in the same cycle as done is ignored; the controller must re-assert it in IDLE.
- mac_clear precedes the first mac_valid by at least one cycle.

Test Plan:
- Basic pass, NUM_INPUTS=4, ROM w={1,2,3,4}, x stream {10,20,30,40}, in_valid and mac_ready held 1 -> pairs (10,1),(20,2),(30,3),(40,4) on 4 consecutive cycles. mac_last only on the 4th pair. done pulses one cycle later; busy drops with it.
- Backpressure: same data, mac_ready toggling 1,0,0,1,... -> rom_r_en=0 and in_ready=0 during stalls. mac_x/mac_w stay stable while stalled. No pair is lost or duplicated, and sum(x*w)=300.
- Input starvation: in_valid low for 3 cycles mid-pass -> mac_valid drops and no ROM read is issued. The address resumes at the correct index and pairs stay aligned.
- Start during busy and re-start: start pulsed mid-pass is ignored. A second start after done gives mac_clear, and addresses restart at 0.
- Reset mid-pass: rst_n=0 after 2 pairs -> next cycle all outputs 0 and state IDLE, with no done pulse. A new start yields addresses from 0.
- NUM_INPUTS=1: one pair with mac_last=1, then done on the cycle after the handshake.

Source files
------------

// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq: walks the weight ROM for one neuron pass, pairs each
// weight with the matching streamed activation and hands {x, w} pairs to the
// MAC over a valid/ready handshake with full backpressure.
//
// Pipeline: stage 1 issues the ROM read and consumes the activation in the
// same cycle; stage 2 holds the pair. The ROM output arrives one cycle after
// the read, which is the same cycle the registered activation appears on
// mac_x, so the weight is passed straight through to mac_w. During a stall no
// read is issued, so the ROM keeps its output and the pair stays coherent
// without a skid buffer.
module weight_fetch_seq #(
   parameter int DATA_SIZE  = 32,
   parameter int ADDR_SIZE  = 10,
   parameter int NUM_INPUTS = 784
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 in_ready,
   output logic [ADDR_SIZE-1:0] rom_r_addr,
   output logic                 rom_r_en,
   input  logic [DATA_SIZE-1:0] rom_weight,
   output logic                 mac_clear,
   output logic                 mac_valid,
   output logic [DATA_SIZE-1:0] mac_x,
   output logic [DATA_SIZE-1:0] mac_w,
   output logic                 mac_last,
   input  logic                 mac_ready
);

   // Index of the final weight, held at counter width so the compare is exact.
   localparam int unsigned          LAST_INT = NUM_INPUTS - 1;
   localparam logic [ADDR_SIZE:0]   LAST_IDX = LAST_INT[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0]   CNT_ZERO = {(ADDR_SIZE+1){1'b0}};
   localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q,     state_d;
   logic [ADDR_SIZE:0]   count_q,     count_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 clear_q,     clear_d;
   logic                 mac_valid_q, mac_valid_d;
   logic                 mac_last_q,  mac_last_d;
   logic [DATA_SIZE-1:0] mac_x_q,     mac_x_d;

   logic advance_s;
   logic issue_s;
   logic is_last_s;

   // Stage 2 can take a new pair when it is empty or its pair is being accepted.
   always_comb begin
      advance_s = ~mac_valid_q | mac_ready;
      issue_s   = (state_q == S_RUN) & in_valid & advance_s;
      is_last_s = (count_q == LAST_IDX);
   end

   // Next-state, counter and output-pair computation.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      clear_d     = 1'b0;
      mac_valid_d = mac_valid_q;
      mac_last_d  = mac_last_q;
      mac_x_d     = mac_x_q;

      // Output pair stage: load on issue, empty when drained, hold on stall.
      if (issue_s) begin
         mac_x_d     = in_data;
         mac_valid_d = 1'b1;
         mac_last_d  = is_last_s;
         count_d     = count_q + CNT_ONE;
      end else if (advance_s) begin
         mac_valid_d = 1'b0;
         mac_last_d  = 1'b0;
      end else begin
         mac_valid_d = mac_valid_q;
         mac_last_d  = mac_last_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               count_d = CNT_ZERO;
               clear_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // Issuing the final address ends the issue phase; the pair drains next.
            if (issue_s && is_last_s) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (mac_valid_q && mac_ready && mac_last_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            // start is not looked at here; the controller re-asserts it in IDLE.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN) | (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs; synchronous active-low reset aborts any pass.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= CNT_ZERO;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clear_q     <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_last_q  <= 1'b0;
         mac_x_q     <= {DATA_SIZE{1'b0}};
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         clear_q     <= clear_d;
         mac_valid_q <= mac_valid_d;
         mac_last_q  <= mac_last_d;
         mac_x_q     <= mac_x_d;
      end
   end

   // The activation is consumed exactly when the matching ROM read is issued.
   always_comb begin
      in_ready   = issue_s;
      rom_r_en   = issue_s;
      rom_r_addr = count_q[ADDR_SIZE-1:0];
      busy       = busy_q;
      done       = done_q;
      mac_clear  = clear_q;
      mac_valid  = mac_valid_q;
      mac_last   = mac_last_q;
      mac_x      = mac_x_q;
      mac_w      = rom_weight;
   end

endmodule
